// File: rtl/approx_add_sched_if.sv
// Request/result bus between the accelerator requesters and the shared approximate adder.
// master = requester/consumer side, slave = scheduler side.
interface approx_add_sched_if #(
   parameter int N_REQ = 4,
   parameter int IDW   = 2
);
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_ready;
   logic [6*N_REQ-1:0] req_a;
   logic [6*N_REQ-1:0] req_b;
   logic               res_valid;
   logic               res_ready;
   logic [6:0]         res_sum;
   logic [IDW-1:0]     res_id;

   modport master (
      output req_valid, req_a, req_b, res_ready,
      input  req_ready, res_valid, res_sum, res_id
   );

   modport slave (
      input  req_valid, req_a, req_b, res_ready,
      output req_ready, res_valid, res_sum, res_id
   );
endinterface

// File: rtl/approx_add_sched.sv
// Round-robin scheduler sharing one 6-bit approximate adder between N_REQ requesters,
// plus the approximate adder itself (lower P bits OR-ed, upper bits exact ripple).
module approx #(
   parameter int p = 4
) (
   input  logic [5:0] a,
   input  logic [5:0] b,
   output logic [6:0] y
);
   generate
      if (p == 0) begin : g_exact
         assign y = {1'b0, a} + {1'b0, b};
      end else begin : g_approx
         logic carry;
         // Carry into the exact part is guessed from the top approximated bit only.
         assign carry    = a[p-1] & b[p-1];
         assign y[p-1:0] = a[p-1:0] | b[p-1:0];
         assign y[6:p]   = {1'b0, a[5:p]} + {1'b0, b[5:p]} + {{(6-p){1'b0}}, carry};
      end
   endgenerate
endmodule

module approx_add_sched #(
   parameter int N_REQ = 4,
   parameter int P     = 4,
   parameter int IDW   = 2
) (
   input  logic                clk,
   input  logic                rst,
   approx_add_sched_if.slave   bus,
   output logic                busy,
   output logic [15:0]         op_count
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_q,     state_d;
   logic [IDW-1:0] ptr_q,       ptr_d;
   logic [5:0]     a_q,         a_d;
   logic [5:0]     b_q,         b_d;
   logic [IDW-1:0] id_q,        id_d;
   logic [6:0]     res_sum_q,   res_sum_d;
   logic [IDW-1:0] res_id_q,    res_id_d;
   logic [15:0]    op_count_q,  op_count_d;

   logic [5:0]     a_arr [N_REQ];
   logic [5:0]     b_arr [N_REQ];
   logic [IDW-1:0] win_id;
   logic           any_valid;
   logic           grant_en;
   logic [6:0]     sum_y;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign a_arr[gi] = bus.req_a[6*gi +: 6];
         assign b_arr[gi] = bus.req_b[6*gi +: 6];
         assign bus.req_ready[gi] = grant_en && (win_id == IDW'(gi));
      end
   endgenerate

   // Scan downward from ptr+N-1 to ptr so the last hit is the first valid at or above ptr.
   always_comb begin
      win_id    = '0;
      any_valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
            win_id    = IDW'((int'(ptr_q) + k) % N_REQ);
            any_valid = 1'b1;
         end
      end
   end

   assign grant_en = any_valid &&
                     ((state_q == IDLE) || ((state_q == DONE) && bus.res_ready));

   approx #(.p(P)) u_approx (
      .a (a_q),
      .b (b_q),
      .y (sum_y)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      res_sum_d  = res_sum_q;
      res_id_d   = res_id_q;
      op_count_d = op_count_q;

      if (state_q == DONE && bus.res_ready) begin
         op_count_d = (op_count_q == 16'hFFFF) ? op_count_q : op_count_q + 16'd1;
         state_d    = IDLE;
      end

      if (state_q == CALC) begin
         res_sum_d = sum_y;
         res_id_d  = id_q;
         state_d   = DONE;
      end

      if (grant_en) begin
         a_d     = a_arr[win_id];
         b_d     = b_arr[win_id];
         id_d    = win_id;
         ptr_d   = (win_id == IDW'(N_REQ - 1)) ? '0 : win_id + IDW'(1);
         state_d = CALC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= '0;
         res_sum_q  <= '0;
         res_id_q   <= '0;
         op_count_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         a_q        <= a_d;
         b_q        <= b_d;
         id_q       <= id_d;
         res_sum_q  <= res_sum_d;
         res_id_q   <= res_id_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.res_valid = (state_q == DONE);
   assign bus.res_sum   = res_sum_q;
   assign bus.res_id    = res_id_q;
   assign busy          = (state_q != IDLE);
   assign op_count      = op_count_q;
endmodule

// File: tb/tb_approx_add_sched.sv
// Directed bench for approx_add_sched (N_REQ=4, P=4) with hand-computed approximate sums.
module tb_approx_add_sched;
   logic        clk;
   logic        rst;
   logic        busy;
   logic [15:0] op_count;
   int          vecs;
   int          errs;

   approx_add_sched_if #(.N_REQ(4), .IDW(2)) bus ();

   approx_add_sched #(.N_REQ(4), .P(4), .IDW(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-requester operands used by the round-robin scenarios and their P=4 sums.
   logic [5:0] rr_a   [4] = '{6'h01, 6'h08, 6'h30, 6'h2F};
   logic [5:0] rr_b   [4] = '{6'h02, 6'h08, 6'h10, 6'h1C};
   logic [6:0] rr_sum [4] = '{7'h03, 7'h18, 7'h40, 7'h4F};

   task automatic cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int id, input logic [5:0] a, input logic [5:0] b);
      bus.req_a[6*id +: 6] = a;
      bus.req_b[6*id +: 6] = b;
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b1;
      cyc;
      rst = 1'b0;
      #1;
   endtask

   // One operation on a single requester; expects res_ready=1 and starts in IDLE.
   task automatic run_op(input int id, input logic [5:0] a, input logic [5:0] b);
      set_req(id, a, b);
      bus.req_valid = 4'(1 << id);
      cyc;
      bus.req_valid = '0;
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      cyc;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.res_ready = 1'b0;
      @(negedge clk);
      vecs++; if (bus.req_ready !== 4'b0000) begin $display("FAIL rst_req_ready got %b exp 0000", bus.req_ready); errs++; end
      vecs++; if (bus.res_valid !== 1'b0) begin $display("FAIL rst_res_valid got %b exp 0", bus.res_valid); errs++; end
      vecs++; if (bus.res_sum !== 7'h00) begin $display("FAIL rst_res_sum got %h exp 00", bus.res_sum); errs++; end
      vecs++; if (bus.res_id !== 2'd0) begin $display("FAIL rst_res_id got %0d exp 0", bus.res_id); errs++; end
      vecs++; if (op_count !== 16'h0000) begin $display("FAIL rst_op_count got %h exp 0000", op_count); errs++; end
      rst = 1'b0;
      set_req(0, 6'h15, 6'h0B);
      bus.req_valid = 4'b0001;
      #1;
      vecs++; if (bus.req_ready !== 4'b0001) begin $display("FAIL rst_first_grant got %b exp 0001", bus.req_ready); errs++; end
      cyc;
      bus.req_valid = '0;
      vecs++; if (busy !== 1'b1) begin $display("FAIL rst_in_calc busy got %b exp 1", busy); errs++; end
      rst = 1'b1;
      #1;
      vecs++; if ({busy, bus.res_valid, bus.res_sum, bus.res_id, bus.req_ready} !== 14'd0)
         begin $display("FAIL rst_mid_calc outputs got busy=%b rv=%b sum=%h id=%0d rdy=%b exp all 0",
                        busy, bus.res_valid, bus.res_sum, bus.res_id, bus.req_ready); errs++; end
      vecs++; if (op_count !== 16'h0000) begin $display("FAIL rst_mid_calc_count got %h exp 0000", op_count); errs++; end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc;
         vecs++; if (bus.res_valid !== 1'b0) begin $display("FAIL rst_no_result cyc %0d got %b exp 0", i, bus.res_valid); errs++; end
      end
      // ptr back at 0: with everything pending, requester 0 must win.
      bus.req_valid = 4'b1111;
      #1;
      vecs++; if (bus.req_ready !== 4'b0001) begin $display("FAIL rst_ptr_zero got %b exp 0001", bus.req_ready); errs++; end
      bus.req_valid = '0;
      #1;
      $display("reset test done");
   endtask

   task automatic test_single;
      bus.res_ready = 1'b1;
      set_req(1, 6'h15, 6'h0B);
      bus.req_valid = 4'b0010;
      #1;
      vecs++; if (bus.req_ready !== 4'b0010) begin $display("FAIL single_grant got %b exp 0010", bus.req_ready); errs++; end
      cyc;
      bus.req_valid = '0;
      vecs++; if (bus.res_valid !== 1'b0) begin $display("FAIL single_calc_valid got %b exp 0", bus.res_valid); errs++; end
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      vecs++; if (bus.res_valid !== 1'b1) begin $display("FAIL single_valid got %b exp 1", bus.res_valid); errs++; end
      vecs++; if (bus.res_sum !== 7'h1F) begin $display("FAIL single_sum got %h exp 1F", bus.res_sum); errs++; end
      vecs++; if (bus.res_id !== 2'd1) begin $display("FAIL single_id got %0d exp 1", bus.res_id); errs++; end
      cyc;
      vecs++; if (op_count !== 16'd1) begin $display("FAIL single_count got %0d exp 1", op_count); errs++; end
      vecs++; if (busy !== 1'b0) begin $display("FAIL single_idle busy got %b exp 0", busy); errs++; end
      set_req(1, 6'h3F, 6'h3F);
      bus.req_valid = 4'b0010;
      cyc;
      bus.req_valid = '0;
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      vecs++; if (bus.res_sum !== 7'h7F) begin $display("FAIL single_max_sum got %h exp 7F", bus.res_sum); errs++; end
      cyc;
      vecs++; if (op_count !== 16'd2) begin $display("FAIL single_count2 got %0d exp 2", op_count); errs++; end
   endtask

   task automatic test_round_robin;
      pulse_reset;
      bus.res_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i]);
      bus.req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         vecs++; if (bus.req_ready !== 4'(1 << (k % 4))) begin $display("FAIL rr_grant %0d got %b exp %b", k, bus.req_ready, 4'(1 << (k % 4))); errs++; end
         cyc;
         vecs++; if ({bus.res_valid, bus.req_ready} !== 5'd0) begin $display("FAIL rr_calc %0d got rv=%b rdy=%b exp 0", k, bus.res_valid, bus.req_ready); errs++; end
         cyc;
         $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
         vecs++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(k % 4) || bus.res_sum !== rr_sum[k % 4])
            begin $display("FAIL rr_result %0d got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                           k, bus.res_valid, bus.res_id, bus.res_sum, k % 4, rr_sum[k % 4]); errs++; end
         vecs++; if (op_count !== 16'(k)) begin $display("FAIL rr_count_mid %0d got %0d exp %0d", k, op_count, k); errs++; end
      end
      bus.req_valid = '0;
      cyc;
      vecs++; if (op_count !== 16'd5) begin $display("FAIL rr_count got %0d exp 5", op_count); errs++; end
      vecs++; if (busy !== 1'b0) begin $display("FAIL rr_idle busy got %b exp 0", busy); errs++; end
   endtask

   task automatic test_backpressure;
      // ptr is 1 here (last grant was requester 0); op_count is 5.
      bus.res_ready = 1'b0;
      set_req(2, rr_a[2], rr_b[2]);
      bus.req_valid = 4'b0100;
      #1;
      vecs++; if (bus.req_ready !== 4'b0100) begin $display("FAIL bp_grant got %b exp 0100", bus.req_ready); errs++; end
      cyc;
      cyc;
      for (int i = 0; i < 10; i++) begin
         vecs++; if (bus.res_valid !== 1'b1 || bus.res_sum !== 7'h40 || bus.res_id !== 2'd2 ||
                     bus.req_ready !== 4'b0000 || op_count !== 16'd5)
            begin $display("FAIL bp_hold cyc %0d got v=%b sum=%h id=%0d rdy=%b cnt=%0d exp v=1 sum=40 id=2 rdy=0000 cnt=5",
                           i, bus.res_valid, bus.res_sum, bus.res_id, bus.req_ready, op_count); errs++; end
         cyc;
      end
      bus.res_ready = 1'b1;
      #1;
      vecs++; if (bus.req_ready !== 4'b0100) begin $display("FAIL bp_release_grant got %b exp 0100", bus.req_ready); errs++; end
      cyc;
      bus.req_valid = '0;
      vecs++; if (op_count !== 16'd6 || busy !== 1'b1) begin $display("FAIL bp_release got cnt=%0d busy=%b exp cnt=6 busy=1", op_count, busy); errs++; end
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      cyc;
      vecs++; if (op_count !== 16'd7) begin $display("FAIL bp_count got %0d exp 7", op_count); errs++; end
   endtask

   task automatic test_ptr_skip;
      pulse_reset;
      bus.res_ready = 1'b1;
      run_op(1, 6'h00, 6'h00);
      set_req(0, rr_a[0], rr_b[0]);
      set_req(3, rr_a[3], rr_b[3]);
      bus.req_valid = 4'b1001;
      #1;
      vecs++; if (bus.req_ready !== 4'b1000) begin $display("FAIL skip_first got %b exp 1000", bus.req_ready); errs++; end
      cyc;
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      vecs++; if (bus.res_id !== 2'd3 || bus.res_sum !== 7'h4F) begin $display("FAIL skip_res3 got id=%0d sum=%h exp id=3 sum=4F", bus.res_id, bus.res_sum); errs++; end
      vecs++; if (bus.req_ready !== 4'b0001) begin $display("FAIL skip_second got %b exp 0001", bus.req_ready); errs++; end
      cyc;
      bus.req_valid = '0;
      cyc;
      $display("result id=%0d sum=%h", bus.res_id, bus.res_sum);
      vecs++; if (bus.res_id !== 2'd0 || bus.res_sum !== 7'h03) begin $display("FAIL skip_res0 got id=%0d sum=%h exp id=0 sum=03", bus.res_id, bus.res_sum); errs++; end
      cyc;
   endtask

   task automatic test_saturate;
      bus.res_ready = 1'b1;
      force dut.op_count_q = 16'hFFFE;
      #1;
      release dut.op_count_q;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         run_op(i, rr_a[i], rr_b[i]);
         vecs++; if (op_count !== 16'hFFFF) begin $display("FAIL sat_count op %0d got %h exp FFFF", i, op_count); errs++; end
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      test_reset;
      test_single;
      test_round_robin;
      test_backpressure;
      test_ptr_skip;
      test_saturate;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
